// File: rtl/mem_interface_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_interface_arbiter
// Purpose  : Shares one downstream memory port between the instruction-cache
//            miss path and the data-cache path. Each requester pulses
//            call_begin for one cycle. The request is captured into a per-
//            requester pending slot and granted round-robin on conflict. One
//            memory transaction runs at a time, and its completion pulse and
//            read data go back to the requester that owns it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, reset_i                     clock, async active-high reset
//   inst_interface_call_begin_i/addr_i instruction request pulse + address
//   inst_interface_return_ready_o      instruction completion pulse
//   inst_interface_rdata_o             instruction read word (valid w/ ready)
//   data_interface_call_begin_i        data request pulse
//   write_enable_i                     1 = write, 0 = read
//   read_size_i, write_size_i          access size for read / write
//   data_interface_raddr_i/waddr_i     read / write address
//   data_interface_wdata_i             write data
//   data_interface_return_ready_o      data completion pulse
//   data_interface_rdata_o             data read word (valid w/ ready)
//   mem_call_begin_o                   one-cycle transaction start
//   mem_wr_o, mem_size_o, mem_addr_o,
//   mem_wdata_o                        transaction fields
//   mem_return_ready_i, mem_rdata_i    memory completion + read data
//   busy_o                             FSM not idle
//   grant_owner_o                      owner of current/last txn (1 = data)
//   timeout_err_o                      sticky forced-completion flag
//   overrun_err_o                      sticky overrun flags [0]=inst [1]=data
// ============================================================================
module mem_interface_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        reset_i,

   input  logic        inst_interface_call_begin_i,
   input  logic [31:0] inst_interface_addr_i,
   output logic        inst_interface_return_ready_o,
   output logic [31:0] inst_interface_rdata_o,

   input  logic        data_interface_call_begin_i,
   input  logic        write_enable_i,
   input  logic [2:0]  read_size_i,
   input  logic [2:0]  write_size_i,
   input  logic [31:0] data_interface_raddr_i,
   input  logic [31:0] data_interface_waddr_i,
   input  logic [31:0] data_interface_wdata_i,
   output logic        data_interface_return_ready_o,
   output logic [31:0] data_interface_rdata_o,

   output logic        mem_call_begin_o,
   output logic        mem_wr_o,
   output logic [2:0]  mem_size_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_return_ready_i,
   input  logic [31:0] mem_rdata_i,

   output logic        busy_o,
   output logic        grant_owner_o,
   output logic        timeout_err_o,
   output logic [1:0]  overrun_err_o
);

   // Counter is wide enough to hold TIMEOUT_CYCLES itself.
   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_TO_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [2:0]       C_INST_SIZE = 3'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Pending request slots.
   logic        inst_pend_q, inst_pend_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   logic        data_pend_q, data_pend_d;
   logic        data_wr_q, data_wr_d;
   logic [2:0]  data_size_q, data_size_d;
   logic [31:0] data_addr_q, data_addr_d;
   logic [31:0] data_wdata_q, data_wdata_d;

   // Arbitration / transaction state.
   logic             last_owner_q, last_owner_d;
   logic             grant_owner_q, grant_owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_cb_q, mem_cb_d;
   logic             mem_wr_q, mem_wr_d;
   logic [2:0]       mem_size_q, mem_size_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;

   // Response path and error flags.
   logic        inst_rdy_q, inst_rdy_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic        data_rdy_q, data_rdy_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic        timeout_err_q, timeout_err_d;
   logic [1:0]  overrun_q, overrun_d;

   // Grant decision (only meaningful in IDLE).
   logic             grant_valid;
   logic             grant_sel;      // 0 = inst, 1 = data
   logic             grant_inst;
   logic             grant_data;
   logic [CNT_W-1:0] cnt_sat;

   always_comb begin
      grant_valid = (state_q == S_IDLE) && (inst_pend_q || data_pend_q);
      // On conflict the requester that did not own the last transaction wins.
      grant_sel   = (inst_pend_q && data_pend_q) ? ~last_owner_q : data_pend_q;
      grant_inst  = grant_valid && !grant_sel;
      grant_data  = grant_valid &&  grant_sel;
      cnt_sat     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // ------------------------------------------------------------------------
   // Request capture. A new pulse on the same edge as the grant re-arms the
   // slot (the granted copy has already been taken by the mem_* registers).
   // A pulse into an ungranted, still-pending slot is dropped and flagged.
   // ------------------------------------------------------------------------
   always_comb begin
      inst_pend_d  = inst_pend_q;
      inst_addr_d  = inst_addr_q;
      data_pend_d  = data_pend_q;
      data_wr_d    = data_wr_q;
      data_size_d  = data_size_q;
      data_addr_d  = data_addr_q;
      data_wdata_d = data_wdata_q;
      overrun_d    = overrun_q;

      if (grant_inst) inst_pend_d = 1'b0;
      if (grant_data) data_pend_d = 1'b0;

      if (inst_interface_call_begin_i) begin
         if (inst_pend_q && !grant_inst) begin
            overrun_d[0] = 1'b1;
         end else begin
            inst_pend_d = 1'b1;
            inst_addr_d = inst_interface_addr_i;
         end
      end

      if (data_interface_call_begin_i) begin
         if (data_pend_q && !grant_data) begin
            overrun_d[1] = 1'b1;
         end else begin
            data_pend_d  = 1'b1;
            data_wr_d    = write_enable_i;
            data_size_d  = write_enable_i ? write_size_i : read_size_i;
            data_addr_d  = write_enable_i ? data_interface_waddr_i
                                          : data_interface_raddr_i;
            data_wdata_d = data_interface_wdata_i;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Transaction FSM: next state and transaction/response registers.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      last_owner_d  = last_owner_q;
      grant_owner_d = grant_owner_q;
      cnt_d         = cnt_q;
      mem_cb_d      = mem_cb_q;
      mem_wr_d      = mem_wr_q;
      mem_size_d    = mem_size_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      inst_rdy_d    = inst_rdy_q;
      inst_rdata_d  = inst_rdata_q;
      data_rdy_d    = data_rdy_q;
      data_rdata_d  = data_rdata_q;
      timeout_err_d = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               mem_cb_d      = 1'b1;
               grant_owner_d = grant_sel;
               last_owner_d  = grant_sel;
               cnt_d         = '0;
               state_d       = S_WAIT;
               if (grant_sel) begin
                  mem_wr_d    = data_wr_q;
                  mem_size_d  = data_size_q;
                  mem_addr_d  = data_addr_q;
                  mem_wdata_d = data_wdata_q;
               end else begin
                  mem_wr_d    = 1'b0;
                  mem_size_d  = C_INST_SIZE;
                  mem_addr_d  = inst_addr_q;
                  mem_wdata_d = '0;
               end
            end
         end

         S_WAIT: begin
            mem_cb_d = 1'b0;
            if (mem_return_ready_i) begin
               if (grant_owner_q) begin
                  data_rdy_d   = 1'b1;
                  data_rdata_d = mem_rdata_i;
               end else begin
                  inst_rdy_d   = 1'b1;
                  inst_rdata_d = mem_rdata_i;
               end
               state_d = S_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_sat == C_TO_VAL)) begin
               // Forced completion: this edge is the TIMEOUT_CYCLES-th
               // WAIT edge without a memory response.
               if (grant_owner_q) begin
                  data_rdy_d   = 1'b1;
                  data_rdata_d = '0;
               end else begin
                  inst_rdy_d   = 1'b1;
                  inst_rdata_d = '0;
               end
               timeout_err_d = 1'b1;
               cnt_d         = cnt_sat;
               state_d       = S_RESP;
            end else begin
               cnt_d = cnt_sat;
            end
         end

         S_RESP: begin
            inst_rdy_d   = 1'b0;
            inst_rdata_d = '0;
            data_rdy_d   = 1'b0;
            data_rdata_d = '0;
            mem_cb_d     = 1'b0;
            mem_wr_d     = 1'b0;
            mem_size_d   = '0;
            mem_addr_d   = '0;
            mem_wdata_d  = '0;
            state_d      = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         inst_pend_q   <= 1'b0;
         inst_addr_q   <= '0;
         data_pend_q   <= 1'b0;
         data_wr_q     <= 1'b0;
         data_size_q   <= '0;
         data_addr_q   <= '0;
         data_wdata_q  <= '0;
         last_owner_q  <= 1'b1;   // inst wins the first conflict
         grant_owner_q <= 1'b0;
         cnt_q         <= '0;
         mem_cb_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_size_q    <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         inst_rdy_q    <= 1'b0;
         inst_rdata_q  <= '0;
         data_rdy_q    <= 1'b0;
         data_rdata_q  <= '0;
         timeout_err_q <= 1'b0;
         overrun_q     <= '0;
      end else begin
         state_q       <= state_d;
         inst_pend_q   <= inst_pend_d;
         inst_addr_q   <= inst_addr_d;
         data_pend_q   <= data_pend_d;
         data_wr_q     <= data_wr_d;
         data_size_q   <= data_size_d;
         data_addr_q   <= data_addr_d;
         data_wdata_q  <= data_wdata_d;
         last_owner_q  <= last_owner_d;
         grant_owner_q <= grant_owner_d;
         cnt_q         <= cnt_d;
         mem_cb_q      <= mem_cb_d;
         mem_wr_q      <= mem_wr_d;
         mem_size_q    <= mem_size_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         inst_rdy_q    <= inst_rdy_d;
         inst_rdata_q  <= inst_rdata_d;
         data_rdy_q    <= data_rdy_d;
         data_rdata_q  <= data_rdata_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign inst_interface_return_ready_o = inst_rdy_q;
   assign inst_interface_rdata_o        = inst_rdata_q;
   assign data_interface_return_ready_o = data_rdy_q;
   assign data_interface_rdata_o        = data_rdata_q;
   assign mem_call_begin_o              = mem_cb_q;
   assign mem_wr_o                      = mem_wr_q;
   assign mem_size_o                    = mem_size_q;
   assign mem_addr_o                    = mem_addr_q;
   assign mem_wdata_o                   = mem_wdata_q;
   assign busy_o                        = (state_q != S_IDLE);
   assign grant_owner_o                 = grant_owner_q;
   assign timeout_err_o                 = timeout_err_q;
   assign overrun_err_o                 = overrun_q;

endmodule
`default_nettype wire
